// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one RV32I OP / OP-IMM / BRANCH instruction into an
// ALU opcode plus operands and holds the result in a single valid/ready slot
// in front of the combinational ALU. Branch compares reuse EQ/SLT/SLTU with an
// invert flag that the execute stage applies to ALU result bit 0.
module alu_issue_stage #(
  parameter int ALU_LENGTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_rs1_val,
  input  logic [31:0]           in_rs2_val,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_LENGTH-1:0] out_opcode,
  output logic [31:0]           out_left,
  output logic [31:0]           out_right,
  output logic                  out_branch,
  output logic                  out_invert,
  output logic [4:0]            out_rd,
  output logic                  out_wb_en,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  issue_count
);

  // ALU opcode encodings shared with the execute stage
  localparam logic [ALU_LENGTH-1:0] ALU_ADD  = ALU_LENGTH'(0);
  localparam logic [ALU_LENGTH-1:0] ALU_SUB  = ALU_LENGTH'(1);
  localparam logic [ALU_LENGTH-1:0] ALU_SLL  = ALU_LENGTH'(2);
  localparam logic [ALU_LENGTH-1:0] ALU_SLT  = ALU_LENGTH'(3);
  localparam logic [ALU_LENGTH-1:0] ALU_SLTU = ALU_LENGTH'(4);
  localparam logic [ALU_LENGTH-1:0] ALU_XOR  = ALU_LENGTH'(5);
  localparam logic [ALU_LENGTH-1:0] ALU_SRL  = ALU_LENGTH'(6);
  localparam logic [ALU_LENGTH-1:0] ALU_SRA  = ALU_LENGTH'(7);
  localparam logic [ALU_LENGTH-1:0] ALU_OR   = ALU_LENGTH'(8);
  localparam logic [ALU_LENGTH-1:0] ALU_AND  = ALU_LENGTH'(9);
  localparam logic [ALU_LENGTH-1:0] ALU_EQ   = ALU_LENGTH'(10);

  // RV32I major opcodes handled here
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [6:0]  major;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm_i;
  logic [31:0] shamt;

  assign major    = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[11:7];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign shamt    = {27'b0, in_instr[24:20]};

  // Decoded values, loaded into the output slot on capture
  logic [ALU_LENGTH-1:0] dec_opcode;
  logic [31:0]           dec_left;
  logic [31:0]           dec_right;
  logic                  dec_branch;
  logic                  dec_invert;
  logic [4:0]            dec_rd;
  logic                  dec_wb_en;
  logic                  dec_illegal;

  // Per-format decode results before legality masking
  logic                  raw_ok;
  logic [ALU_LENGTH-1:0] raw_opcode;
  logic                  raw_use_rs2;
  logic                  raw_use_shamt;
  logic                  raw_branch;
  logic                  raw_invert;

  // Base funct3 -> ALU op map shared by OP (funct7=0) and OP-IMM non-shifts
  function automatic logic [ALU_LENGTH-1:0] base_op(input logic [2:0] f3);
    logic [ALU_LENGTH-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Classify the instruction: legality, ALU op, operand sources, branch flags
  always_comb begin
    raw_ok        = 1'b0;
    raw_opcode    = ALU_ADD;
    raw_use_rs2   = 1'b0;
    raw_use_shamt = 1'b0;
    raw_branch    = 1'b0;
    raw_invert    = 1'b0;
    case (major)
      OPC_OP: begin
        raw_use_rs2 = 1'b1;
        if (funct7 == F7_BASE) begin
          raw_ok     = 1'b1;
          raw_opcode = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          raw_ok     = 1'b1;
          raw_opcode = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          raw_ok     = 1'b1;
          raw_opcode = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          raw_use_shamt = 1'b1;
          raw_ok        = (funct7 == F7_BASE);
          raw_opcode    = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          raw_use_shamt = 1'b1;
          raw_ok        = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          raw_opcode    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          raw_ok     = 1'b1;
          raw_opcode = base_op(funct3);
        end
      end
      OPC_BRANCH: begin
        raw_use_rs2 = 1'b1;
        raw_branch  = 1'b1;
        raw_invert  = funct3[0];
        case (funct3[2:1])
          2'b00: begin
            raw_ok     = 1'b1;
            raw_opcode = ALU_EQ;
          end
          2'b10: begin
            raw_ok     = 1'b1;
            raw_opcode = ALU_SLT;
          end
          2'b11: begin
            raw_ok     = 1'b1;
            raw_opcode = ALU_SLTU;
          end
          default: raw_ok = 1'b0;
        endcase
      end
      default: raw_ok = 1'b0;
    endcase
  end

  // Build the slot contents; an illegal word becomes a harmless ADD 0,0
  always_comb begin
    dec_opcode  = ALU_ADD;
    dec_left    = 32'b0;
    dec_right   = 32'b0;
    dec_branch  = 1'b0;
    dec_invert  = 1'b0;
    dec_rd      = 5'b0;
    dec_wb_en   = 1'b0;
    dec_illegal = 1'b1;
    if (raw_ok) begin
      dec_illegal = 1'b0;
      dec_opcode  = raw_opcode;
      dec_left    = in_rs1_val;
      if (raw_use_rs2) begin
        dec_right = in_rs2_val;
      end else if (raw_use_shamt) begin
        dec_right = shamt;
      end else begin
        dec_right = imm_i;
      end
      dec_branch = raw_branch;
      dec_invert = raw_invert;
      if (!raw_branch) begin
        dec_rd    = rd_field;
        dec_wb_en = (rd_field != 5'b0);
      end
    end
  end

  // Slot control
  logic out_valid_reg;
  logic capture;
  logic handshake;

  assign in_ready  = !out_valid_reg || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign handshake = out_valid_reg && out_ready && !flush;
  assign out_valid = out_valid_reg;

  // Valid bit: flush kills the slot and any same-cycle capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (capture) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Data registers only move on capture, so a stalled entry stays stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_opcode  <= ALU_ADD;
      out_left    <= 32'b0;
      out_right   <= 32'b0;
      out_branch  <= 1'b0;
      out_invert  <= 1'b0;
      out_rd      <= 5'b0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (capture) begin
      out_opcode  <= dec_opcode;
      out_left    <= dec_left;
      out_right   <= dec_right;
      out_branch  <= dec_branch;
      out_invert  <= dec_invert;
      out_rd      <= dec_rd;
      out_wb_en   <= dec_wb_en;
      out_illegal <= dec_illegal;
    end
  end

  // Issued-instruction counter, wraps naturally at full scale
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_count <= '0;
    end else if (handshake) begin
      issue_count <= issue_count + 1'b1;
    end
  end

endmodule
